pixel_shifter: RTL
==================

Name: pixel_shifter

Overview:
- Downstream consumer of the CRTC timing outputs (hsync, vsync, hden, vden).
- Prefetches 16-bit framebuffer words from video memory into a small FIFO.
- Serialises each word into 1/2/4 bpp colour indices, MSB first, aligned to the display-enable window.
- Outputs registered colour index plus timing delayed by one dot clock, for the palette/DAC stage.

Parameters:
- AW, 20, word address width of video memory.
- DEPTH, 4, prefetch FIFO depth in words (power of two, >=2).

Ports:
- dotclk_i  in  1  dot clock; all state on rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- hsync_i  in  1  CRTC horizontal sync.
- vsync_i  in  1  CRTC vertical sync.
- hden_i  in  1  CRTC horizontal display enable.
- vden_i  in  1  CRTC vertical display enable.
- bpp_i  in  2  depth select: 0=1bpp, 1=2bpp, 2 or 3=4bpp.
- fb_base_i  in  AW  framebuffer word address of the first pixel of a frame.
- mem_cyc_o  out  1  read request.
- mem_adr_o  out  AW  read word address.
- mem_ack_i  in  1  read data valid / request complete.
- mem_dat_i  in  16  read data.
- pix_o  out  4  colour index, zero-extended for 1/2 bpp.
- den_o  out  1  hden_i & vden_i delayed 1 clock.
- hsync_o  out  1  hsync_i delayed 1 clock.
- vsync_o  out  1  vsync_i delayed 1 clock.
- underrun_o  out  1  sticky FIFO-underrun flag.

Behaviour:
- Reset (async, reset_ni=0): all outputs 0, FIFO empty, shift count 0, fetch disabled, drop flag 0.
- Frame start = vsync_i rising edge, i.e. vsync_i=1 and previous sampled value 0. On that edge:
  - Flush the FIFO and clear the shift count.
  - Load mem_adr_o <= fb_base_i.
  - Clear underrun_o and enable fetch.
  - No fetch occurs after reset until the first frame start.
- Fetch:
  - Issue a request (mem_cyc_o<=1) when fetch is enabled, no request is outstanding, and FIFO count < DEPTH.
  - Only one request is outstanding at a time.
  - mem_cyc_o and mem_adr_o stay stable until mem_ack_i is sampled high.
  - On ack: write mem_dat_i into the FIFO, mem_adr_o += 1 (wraps modulo 2^AW), and drop mem_cyc_o for at least one cycle.
  - Fetching continues during blanking until the FIFO is full.
- Frame start while a request is outstanding:
  - Keep mem_cyc_o asserted until ack and set the drop flag.
  - The acked data is discarded and the address is not incremented.
  - The next request uses fb_base_i.
- Simultaneous FIFO write and pop in one cycle is legal; count is unchanged.
- Shifter: runs only on cycles where active = hden_i & vden_i.
  - Pixels per word: 16, 8 or 4 for 1, 2 or 4 bpp.
  - If the shift count is 0 and the FIFO is non-empty: pop the head word, emit its top pixel this cycle (head bypass), store the remainder, and set count = ppw-1.
  - If the shift count is >0: emit the next MSB-first pixel and decrement the count.
  - bpp_i is latched at word load and ignored mid-word.
- Underrun: active, count 0 and FIFO empty.
  - Emit index 0 and set underrun_o (sticky until next frame start).
  - No pop occurs; the next pixel retries the load.
- Output register (latency 1): on each clock,
  - den_o <= active; hsync_o <= hsync_i; vsync_o <= vsync_i.
  - pix_o <= emitted pixel when active, else 0.
- Residual pixels left in the shift register when active deasserts are held and continue on the next active cycle. Line length × bpp that is not a multiple of 16 therefore packs continuously.
- A FIFO write is ignored when the FIFO is full. This cannot happen by construction; the bench asserts it never does.

Decomposition:
- Shared package holds:
  - BPP_1=2'd0, BPP_2=2'd1, BPP_4=2'd2.
  - PIX_W=4, WORD_W=16.
  - A pixels-per-word function.
- One sub-module, pixel_fifo: synchronous DEPTH×16 FIFO with push, pop, head data, count, full and empty, plus a flush input. Async active-low reset.

Test Plan:
- Reset then frame start with fb_base_i=0x100, mem_ack_i returned 1 cycle after cyc → addresses 0x100..0x103 requested, then mem_cyc_o stays 0 with the FIFO full (4 words).
- 1bpp, FIFO head 0xA5F0, active held 16 cycles → pix_o sequence 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0 starting one clock after active rises, and den_o follows active delayed by 1.
- 4bpp, words 0x1234 then 0x5678, active 8 cycles → pix_o 1..8, exactly 2 pops, and the next fetch address increments by 1 per ack.
- 2bpp, word 0xE400, active for 3 cycles, idle for 5, then active for 5 → pix_o 3,2,1 then 0,0,0,0,0, and no pop until the 9th active pixel.
- mem_ack_i withheld, FIFO drained by active → pix_o 0 and underrun_o=1. underrun_o stays 1 through blanking and clears on the next vsync_i rising edge.
- vsync_i rises with a request outstanding (adr 0x205) and ack arrives 3 cycles later with 0xFFFF → data discarded, FIFO empty, and the next request goes to fb_base_i.

Source files
------------

// File: rtl/pixel_shifter_pkg.sv
// Shared definitions for the pixel shifter: depth encodings, widths and
// helpers that pick and shift out MSB-first pixels from a framebuffer word.
package pixel_shifter_pkg;

    localparam logic [1:0] BPP_1 = 2'd0;
    localparam logic [1:0] BPP_2 = 2'd1;
    localparam logic [1:0] BPP_4 = 2'd2;   // 2'd3 also selects 4 bpp

    localparam int PIX_W  = 4;
    localparam int WORD_W = 16;

    // Pixels per 16-bit word for a depth select.
    function automatic logic [4:0] ppw(input logic [1:0] bpp);
        case (bpp)
            BPP_1:   ppw = 5'd16;
            BPP_2:   ppw = 5'd8;
            default: ppw = 5'd4;
        endcase
    endfunction

    // Top (leftmost) pixel of a word, zero-extended to PIX_W.
    function automatic logic [PIX_W-1:0] top_pix(input logic [WORD_W-1:0] w,
                                                 input logic [1:0] bpp);
        case (bpp)
            BPP_1:   top_pix = {3'b000, w[15]};
            BPP_2:   top_pix = {2'b00, w[15:14]};
            default: top_pix = w[15:12];
        endcase
    endfunction

    // Word with its top pixel removed (next pixel moves to the MSBs).
    function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] w,
                                                    input logic [1:0] bpp);
        case (bpp)
            BPP_1:   shift_out = w << 1;
            BPP_2:   shift_out = w << 2;
            default: shift_out = w << 4;
        endcase
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Prefetch FIFO, DEPTH x 16-bit words.
// Ports: clk_i/rst_ni (async active-low), flush_i empties the FIFO,
// push_i/wdata_i write, pop_i advances the head, rdata_o is the head word,
// count_o/full_o/empty_o report occupancy. Push when full and pop when
// empty are ignored.
module pixel_fifo
    import pixel_shifter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + PW'(1);
            if (do_pop)  rp_q <= rp_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end

endmodule

// File: rtl/pixel_shifter.sv
// Pixel shifter: prefetches framebuffer words into a FIFO and serialises
// them into 1/2/4 bpp colour indices during the display-enable window.
// Ports: dotclk_i/reset_ni; CRTC timing hsync_i/vsync_i/hden_i/vden_i;
// bpp_i depth select; fb_base_i frame start address; memory read port
// mem_cyc_o/mem_adr_o/mem_ack_i/mem_dat_i; registered outputs pix_o,
// den_o, hsync_o, vsync_o (one dot clock latency); sticky underrun_o.
module pixel_shifter
    import pixel_shifter_pkg::*;
#(
    parameter int AW    = 20,
    parameter int DEPTH = 4
) (
    input  logic              dotclk_i,
    input  logic              reset_ni,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              hden_i,
    input  logic              vden_i,
    input  logic [1:0]        bpp_i,
    input  logic [AW-1:0]     fb_base_i,
    output logic              mem_cyc_o,
    output logic [AW-1:0]     mem_adr_o,
    input  logic              mem_ack_i,
    input  logic [WORD_W-1:0] mem_dat_i,
    output logic [PIX_W-1:0]  pix_o,
    output logic              den_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              underrun_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              cyc_q, cyc_d, fetch_en_q, fetch_en_d, drop_q, drop_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        bpp_q, bpp_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              den_q, hs_q, vs_q, und_q, und_d;

    logic              wr_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_cnt;
    logic              active, frame_start, und_set;

    assign active      = hden_i & vden_i;
    // vs_q is both the delayed vsync output and the edge-detect history.
    assign frame_start = vsync_i & ~vs_q;

    assign fifo_push   = wr_req & ~fifo_full;

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (dotclk_i),
        .rst_ni  (reset_ni),
        .flush_i (frame_start),
        .push_i  (fifo_push),
        .wdata_i (mem_dat_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Fetch side: single outstanding request, address held until ack.
    always_comb begin
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        fetch_en_d = fetch_en_q;
        drop_d     = drop_q;
        wr_req     = 1'b0;
        if (frame_start) begin
            fetch_en_d = 1'b1;
            if (cyc_q && !mem_ack_i) begin
                // Let the old-frame request finish; its data is discarded.
                drop_d = 1'b1;
            end else begin
                cyc_d  = 1'b0;
                drop_d = 1'b0;
                adr_d  = fb_base_i;
            end
        end else if (cyc_q) begin
            if (mem_ack_i) begin
                cyc_d  = 1'b0;
                drop_d = 1'b0;
                if (drop_q) begin
                    adr_d = fb_base_i;
                end else begin
                    adr_d  = adr_q + AW'(1);
                    wr_req = 1'b1;
                end
            end
        end else if (fetch_en_q && fifo_cnt < CW'(DEPTH)) begin
            cyc_d = 1'b1;
        end
    end

    // Shifter: head-bypass on word load so a load cycle still emits a pixel.
    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        bpp_d    = bpp_q;
        pix_d    = '0;
        fifo_pop = 1'b0;
        und_set  = 1'b0;
        if (active) begin
            if (cnt_q == 5'd0) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    bpp_d    = bpp_i;
                    pix_d    = top_pix(fifo_head, bpp_i);
                    sh_d     = shift_out(fifo_head, bpp_i);
                    cnt_d    = ppw(bpp_i) - 5'd1;
                end else begin
                    und_set  = 1'b1;
                end
            end else begin
                pix_d = top_pix(sh_q, bpp_q);
                sh_d  = shift_out(sh_q, bpp_q);
                cnt_d = cnt_q - 5'd1;
            end
        end
        if (frame_start) cnt_d = 5'd0;
        und_d = frame_start ? 1'b0 : (und_q | und_set);
    end

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cyc_q      <= 1'b0;
            adr_q      <= '0;
            fetch_en_q <= 1'b0;
            drop_q     <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            bpp_q      <= '0;
            pix_q      <= '0;
            den_q      <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            fetch_en_q <= fetch_en_d;
            drop_q     <= drop_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            bpp_q      <= bpp_d;
            pix_q      <= pix_d;
            den_q      <= active;
            hs_q       <= hsync_i;
            vs_q       <= vsync_i;
            und_q      <= und_d;
        end
    end

    assign mem_cyc_o  = cyc_q;
    assign mem_adr_o  = adr_q;
    assign pix_o      = pix_q;
    assign den_o      = den_q;
    assign hsync_o    = hs_q;
    assign vsync_o    = vs_q;
    assign underrun_o = und_q;

endmodule
